// File: rtl/axi_rd_master_mux.sv
// axi_rd_master_mux: routes the arbiter-granted master's AR channel and the
// returning R burst to and from one slave port, one read in flight at a time.
// Optional feature macro: RD_TIMEOUT_EN (synthesises an SLVERR/RLAST response
// when the slave stops returning R beats for TIMEOUT cycles).
module axi_rd_master_mux #(
  parameter int MASTERS = 2,
  parameter int IDW     = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [MASTERS*IDW-1:0] ARID_M,
  input  logic [MASTERS*AW-1:0]  ARADDR_M,
  input  logic [MASTERS*4-1:0]   ARLEN_M,
  input  logic [MASTERS*3-1:0]   ARSIZE_M,
  input  logic [MASTERS*2-1:0]   ARBURST_M,
  input  logic [MASTERS-1:0]     ARVALID_M,
  output logic [MASTERS-1:0]     ARREADY_M,
  output logic [IDW-1:0]         RID_M,
  output logic [DW-1:0]          RDATA_M,
  output logic [1:0]             RRESP_M,
  output logic                   RLAST_M,
  output logic [MASTERS-1:0]     RVALID_M,
  input  logic [MASTERS-1:0]     RREADY_M,
  output logic [IDW-1:0]         ARID_S,
  output logic [AW-1:0]          ARADDR_S,
  output logic [3:0]             ARLEN_S,
  output logic [2:0]             ARSIZE_S,
  output logic [1:0]             ARBURST_S,
  output logic                   ARVALID_S,
  input  logic                   ARREADY_S,
  input  logic [IDW-1:0]         RID_S,
  input  logic [DW-1:0]          RDATA_S,
  input  logic [1:0]             RRESP_S,
  input  logic                   RLAST_S,
  input  logic                   RVALID_S,
  output logic                   RREADY_S,
  output logic [MASTERS-1:0]     req_o,
  output logic [MASTERS-1:0]     done_o,
  input  logic [MASTERS-1:0]     grant_i
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_WAIT} state_t;

  localparam logic [MASTERS-1:0] ONE = MASTERS'(1);

  state_t             state, state_nxt;
  logic [MASTERS-1:0] sel;
  logic [IDW-1:0]     id_q;

  logic [IDW-1:0]     own_id, gnt_id;
  logic [AW-1:0]      own_addr;
  logic [3:0]         own_len;
  logic [2:0]         own_size;
  logic [1:0]         own_burst;
  logic               own_arvalid, own_rready;
  logic               grant_ok;
  logic               to_hit;

  // Accept only a single-bit grant that targets a master actually requesting.
  assign grant_ok = (grant_i != '0) && ((grant_i & (grant_i - ONE)) == '0) &&
                    ((ARVALID_M & grant_i) != '0);

  // One-hot select of the owner's AR payload / RREADY and of the granted ARID.
  always_comb begin
    own_id      = '0;
    own_addr    = '0;
    own_len     = '0;
    own_size    = '0;
    own_burst   = '0;
    own_arvalid = 1'b0;
    own_rready  = 1'b0;
    gnt_id      = '0;
    for (int i = 0; i < MASTERS; i++) begin
      if (sel[i]) begin
        own_id      = ARID_M[i*IDW +: IDW];
        own_addr    = ARADDR_M[i*AW +: AW];
        own_len     = ARLEN_M[i*4 +: 4];
        own_size    = ARSIZE_M[i*3 +: 3];
        own_burst   = ARBURST_M[i*2 +: 2];
        own_arvalid = ARVALID_M[i];
        own_rready  = RREADY_M[i];
      end
      if (grant_i[i]) gnt_id = ARID_M[i*IDW +: IDW];
    end
  end

`ifdef RD_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] to_cnt;

  assign to_hit = (state == S_DATA) && (to_cnt == CW'(TIMEOUT));

  // Beat-gap counter: zeroed while addressing and on every R handshake,
  // saturates at TIMEOUT so the error response stays asserted.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      to_cnt <= '0;
    end else if (state == S_ADDR) begin
      to_cnt <= '0;
    end else if (state == S_DATA) begin
      if (RVALID_S && RREADY_S) to_cnt <= '0;
      else if (!to_hit)         to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  // id_q and TIMEOUT only feed the timeout response; keep them visibly sunk.
  logic timeout_unused;
  assign to_hit         = 1'b0;
  assign timeout_unused = (TIMEOUT != 0) ^ (^id_q);
`endif

  // State, owner and owner-ID registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= S_IDLE;
      sel   <= '0;
      id_q  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && grant_ok) begin
        sel  <= grant_i;
        id_q <= gnt_id;
      end
    end
  end

  // Next-state and channel routing; everything idles at zero outside its phase.
  always_comb begin
    state_nxt = state;
    ARREADY_M = '0;
    RID_M     = '0;
    RDATA_M   = '0;
    RRESP_M   = 2'b00;
    RLAST_M   = 1'b0;
    RVALID_M  = '0;
    ARID_S    = '0;
    ARADDR_S  = '0;
    ARLEN_S   = '0;
    ARSIZE_S  = '0;
    ARBURST_S = '0;
    ARVALID_S = 1'b0;
    RREADY_S  = 1'b0;
    req_o     = '0;
    done_o    = '0;
    case (state)
      S_IDLE: begin
        req_o = ARESETn ? ARVALID_M : '0;
        if (grant_ok) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        ARID_S    = own_id;
        ARADDR_S  = own_addr;
        ARLEN_S   = own_len;
        ARSIZE_S  = own_size;
        ARBURST_S = own_burst;
        ARVALID_S = own_arvalid;
        ARREADY_M = sel & {MASTERS{ARREADY_S}};
        if (own_arvalid && ARREADY_S) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (to_hit) begin
          RVALID_M = sel;
          RRESP_M  = 2'b10;
          RLAST_M  = 1'b1;
          RID_M    = id_q;
          if (own_rready) begin
            done_o    = sel;
            state_nxt = S_WAIT;
          end
        end else begin
          RVALID_M = sel & {MASTERS{RVALID_S}};
          RID_M    = RID_S;
          RDATA_M  = RDATA_S;
          RRESP_M  = RRESP_S;
          RLAST_M  = RLAST_S;
          RREADY_S = own_rready;
          if (RVALID_S && own_rready && RLAST_S) begin
            done_o    = sel;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_master_mux.sv
// Testbench for axi_rd_master_mux: directed phase checks followed by random
// traffic against a transaction-level model (masters, slave, arbiter).
module tb_axi_rd_master_mux;
  localparam int NM  = 2;
  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TO  = 16;

  logic              ACLK, ARESETn;
  logic [NM*IDW-1:0] ARID_M;
  logic [NM*AW-1:0]  ARADDR_M;
  logic [NM*4-1:0]   ARLEN_M;
  logic [NM*3-1:0]   ARSIZE_M;
  logic [NM*2-1:0]   ARBURST_M;
  logic [NM-1:0]     ARVALID_M, ARREADY_M, RVALID_M, RREADY_M;
  logic [IDW-1:0]    RID_M, ARID_S, RID_S;
  logic [DW-1:0]     RDATA_M, RDATA_S;
  logic [1:0]        RRESP_M, RRESP_S, ARBURST_S;
  logic              RLAST_M, RLAST_S, RVALID_S, RREADY_S, ARVALID_S, ARREADY_S;
  logic [AW-1:0]     ARADDR_S;
  logic [3:0]        ARLEN_S;
  logic [2:0]        ARSIZE_S;
  logic [NM-1:0]     req_o, done_o, grant_i;

  int n_tests = 0;
  int n_fail  = 0;

  axi_rd_master_mux #(.MASTERS(NM), .IDW(IDW), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
    .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
    .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
    .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S), .ARSIZE_S(ARSIZE_S),
    .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S), .RLAST_S(RLAST_S),
    .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .req_o(req_o), .done_o(done_o), .grant_i(grant_i)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic any_out();
    return |{ARREADY_M, RID_M, RDATA_M, RRESP_M, RLAST_M, RVALID_M, ARID_S, ARADDR_S,
             ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S, req_o, done_o};
  endfunction

  task automatic set_ar(input int m, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                        input logic [3:0] len);
    ARID_M[m*IDW +: IDW]  = id;
    ARADDR_M[m*AW +: AW]  = addr;
    ARLEN_M[m*4 +: 4]     = len;
    ARSIZE_M[m*3 +: 3]    = 3'd2;
    ARBURST_M[m*2 +: 2]   = 2'b01;
    ARVALID_M[m]          = 1'b1;
  endtask

  // Transaction-level model state
  logic           m_pend [NM];
  logic           m_out  [NM];
  logic [IDW-1:0] m_id   [NM];
  logic [AW-1:0]  m_addr [NM];
  logic [3:0]     m_len  [NM];
  logic [3:0]     m_beat [NM];
  int             m_done [NM];
  logic           s_busy;
  logic [IDW-1:0] s_id;
  logic [AW-1:0]  s_addr;
  logic [3:0]     s_len, s_beat;
  logic [NM-1:0]  gnt;
  int             rr;

  initial begin
    logic          issue, idle_all, s_hs, s_ar, found;
    logic [NM-1:0] m_hs, m_arhs, exp_done, out_mask, pend_mask;
    logic [AW-1:0] a;
    int            owner;

    ARESETn = 1'b0;
    ARID_M = '0; ARADDR_M = '0; ARLEN_M = '0; ARSIZE_M = '0; ARBURST_M = '0;
    ARVALID_M = 2'b11; RREADY_M = 2'b11; ARREADY_S = 1'b1;
    RID_S = '0; RDATA_S = 32'hDEAD_BEEF; RRESP_S = '0; RLAST_S = 1'b1; RVALID_S = 1'b1;
    grant_i = 2'b01;
    #1;
    check("reset_outs", any_out(), 1'b0);
    cyc(); cyc();
    ARESETn = 1'b1;
    ARVALID_M = '0; RREADY_M = '0; ARREADY_S = 1'b0; RVALID_S = 1'b0; RLAST_S = 1'b0;
    grant_i = '0;
    #1;
    check("post_reset_outs", any_out(), 1'b0);

    // Single read: M0, ARADDR 0x100, ARLEN 3
    cyc();
    set_ar(0, 4'd2, 32'h100, 4'd3);
    grant_i = 2'b01;
    #1;
    check("idle_req", req_o, 2'b01);
    check("idle_arvalid_s", ARVALID_S, 1'b0);
    cyc();
    check("addr_arvalid_s", ARVALID_S, 1'b1);
    check("addr_araddr_s", ARADDR_S, 32'h100);
    check("addr_arlen_s", ARLEN_S, 4'd3);
    check("addr_arid_s", ARID_S, 4'd2);
    check("addr_req", req_o, 2'b00);
    check("addr_arready_stall", ARREADY_M, 2'b00);
    ARREADY_S = 1'b1;
    #1;
    check("addr_arready", ARREADY_M, 2'b01);
    cyc();
    ARVALID_M = '0; ARREADY_S = 1'b0; grant_i = '0; RREADY_M = 2'b11;
    for (int b = 0; b < 4; b++) begin
      RVALID_S = 1'b1; RID_S = 4'd2; RDATA_S = 32'h100 + b; RLAST_S = (b == 3);
      #1;
      check("beat_rvalid", RVALID_M, 2'b01);
      check("beat_rdata", RDATA_M, 32'h100 + b);
      check("beat_rlast", RLAST_M, (b == 3));
      check("beat_done", done_o, (b == 3) ? 2'b01 : 2'b00);
      cyc();
    end
    RVALID_S = 1'b0; RLAST_S = 1'b0;
    set_ar(0, 4'd2, 32'h100, 4'd3);
    grant_i = 2'b01;
    #1;
    check("wait_quiet", any_out(), 1'b0);
    cyc();
    check("back_to_idle", req_o, 2'b01);
    ARVALID_M = '0; grant_i = '0; RREADY_M = '0;
    cyc();

    // Bad grants
    set_ar(0, 4'd1, 32'h40, 4'd0);
    grant_i = 2'b11;
    cyc();
    check("bad_grant_11", ARVALID_S, 1'b0);
    grant_i = 2'b10;
    cyc();
    check("bad_grant_novalid", ARVALID_S, 1'b0);
    check("bad_grant_idle", req_o, 2'b01);
    grant_i = 2'b00;
    cyc();
    check("zero_grant", ARVALID_S, 1'b0);
    ARVALID_M = '0;
    cyc();

    // Reset during the second beat of a 4-beat burst from M1
    set_ar(1, 4'd5, 32'h200, 4'd3);
    grant_i = 2'b10;
    cyc();
    ARREADY_S = 1'b1;
    #1;
    check("m1_arready", ARREADY_M, 2'b10);
    cyc();
    ARVALID_M = '0; ARREADY_S = 1'b0; grant_i = '0; RREADY_M = 2'b10;
    RVALID_S = 1'b1; RID_S = 4'd5; RDATA_S = 32'h200;
    #1;
    check("m1_rid", RID_M, 4'd5);
    check("m1_rvalid_only", RVALID_M, 2'b10);
    cyc();
    RDATA_S = 32'h201;
    #1;
    check("m1_beat2_rvalid", RVALID_M, 2'b10);
    ARESETn = 1'b0;
    #1;
    check("mid_reset_outs", any_out(), 1'b0);
    cyc(); cyc();
    ARESETn = 1'b1;
    RVALID_S = 1'b0; RREADY_M = '0;
    ARVALID_M = 2'b10;
    #1;
    check("reset_release_idle", req_o, 2'b10);
    check("reset_release_quiet", RVALID_M, 2'b00);
    ARVALID_M = '0;
    cyc();

`ifdef RD_TIMEOUT_EN
    // Slave accepts AR and never answers
    set_ar(0, 4'd9, 32'h300, 4'd1);
    grant_i = 2'b01;
    cyc();
    ARREADY_S = 1'b1;
    cyc();
    ARVALID_M = '0; ARREADY_S = 1'b0; grant_i = '0; RREADY_M = '0; RVALID_S = 1'b0;
    for (int k = 0; k < TO; k++) begin
      #1;
      check("to_quiet", RVALID_M, 2'b00);
      cyc();
    end
    #1;
    check("to_rvalid", RVALID_M, 2'b01);
    check("to_rresp", RRESP_M, 2'b10);
    check("to_rlast", RLAST_M, 1'b1);
    check("to_rid", RID_M, 4'd9);
    check("to_rdata", RDATA_M, 32'h0);
    check("to_no_done", done_o, 2'b00);
    cyc();
    check("to_hold", RVALID_M, 2'b01);
    RVALID_S = 1'b1; RDATA_S = 32'h1234; RREADY_M = 2'b01;
    #1;
    check("to_rready_s", RREADY_S, 1'b0);
    check("to_done", done_o, 2'b01);
    check("to_hold_data", RDATA_M, 32'h0);
    cyc();
    RVALID_S = 1'b0; RREADY_M = '0;
    #1;
    check("to_wait_quiet", any_out(), 1'b0);
    cyc();
`endif

    // Random traffic against the transaction model
    for (int i = 0; i < NM; i++) begin
      m_pend[i] = 0; m_out[i] = 0; m_beat[i] = 0; m_done[i] = 0;
      m_id[i] = '0; m_addr[i] = '0; m_len[i] = '0;
    end
    s_busy = 0; s_id = '0; s_addr = '0; s_len = '0; s_beat = '0;
    gnt = '0; rr = 0;
    for (int n = 0; n < 3300; n++) begin
      issue = (n < 3000);
      idle_all = !s_busy;
      for (int i = 0; i < NM; i++) idle_all = idle_all && !m_pend[i] && !m_out[i];
      if (!issue && idle_all) break;
      cyc();
      for (int i = 0; i < NM; i++) begin
        if (issue && !m_pend[i] && !m_out[i] && $urandom_range(2) == 0) begin
          m_pend[i] = 1;
          m_id[i]   = IDW'($urandom);
          m_addr[i] = $urandom & 32'hFFFF_FFF0;
          m_len[i]  = 4'($urandom_range(15));
          set_ar(i, m_id[i], m_addr[i], m_len[i]);
        end
        ARVALID_M[i] = m_pend[i];
        RREADY_M[i]  = ($urandom_range(7) != 0);
      end
      ARREADY_S = $urandom_range(1);
      if (s_busy) begin
        a        = s_addr + s_beat;
        RVALID_S = ($urandom_range(7) != 0);
        RID_S    = s_id;
        RDATA_S  = a ^ 32'h5A5A_0000;
        RRESP_S  = a[1:0];
        RLAST_S  = (s_beat == s_len);
      end else begin
        RVALID_S = ($urandom_range(3) == 0);
        RID_S    = IDW'($urandom);
        RDATA_S  = $urandom;
        RRESP_S  = 2'($urandom);
        RLAST_S  = $urandom_range(1);
      end
      grant_i = gnt;
      #1;
      out_mask = '0; pend_mask = '0; owner = 0;
      for (int i = 0; i < NM; i++) begin
        out_mask[i]  = m_out[i];
        pend_mask[i] = m_pend[i];
        if (m_out[i]) owner = i;
      end
      m_hs     = RVALID_M & RREADY_M & out_mask;
      m_arhs   = ARVALID_M & ARREADY_M;
      s_hs     = s_busy && RVALID_S && RREADY_S;
      s_ar     = ARVALID_S && ARREADY_S;
      exp_done = '0;
      for (int i = 0; i < NM; i++) exp_done[i] = m_hs[i] && (m_beat[i] == m_len[i]);
      check("rvalid_owner", RVALID_M & ~out_mask, '0);
      check("arready_inflight", ARREADY_M & {NM{|out_mask}}, '0);
      check("arready_pending", ARREADY_M & ~pend_mask, '0);
      check("done_pulse", done_o, exp_done);
      check("r_hs_sync", s_hs, |m_hs);
      check("ar_hs_sync", s_ar, |m_arhs);
      check("rready_idle", RREADY_S & ~s_busy, 1'b0);
      if (s_busy) check("rready_pass", RREADY_S, RREADY_M[owner]);
      for (int i = 0; i < NM; i++) begin
        if (m_arhs[i]) begin
          check("ar_addr", ARADDR_S, m_addr[i]);
          check("ar_id", ARID_S, m_id[i]);
          check("ar_len", ARLEN_S, m_len[i]);
          check("ar_size_burst", {ARSIZE_S, ARBURST_S}, {3'd2, 2'b01});
        end
        if (m_hs[i]) begin
          a = m_addr[i] + m_beat[i];
          check("r_data", RDATA_M, a ^ 32'h5A5A_0000);
          check("r_id", RID_M, m_id[i]);
          check("r_resp", RRESP_M, a[1:0]);
          check("r_last", RLAST_M, (m_beat[i] == m_len[i]));
        end
      end
      // model update
      if (s_hs) begin
        if (s_beat == s_len) s_busy = 0;
        s_beat = s_beat + 1'b1;
      end
      if (s_ar && !s_busy) begin
        s_busy = 1; s_id = ARID_S; s_addr = ARADDR_S; s_len = ARLEN_S; s_beat = '0;
      end
      for (int i = 0; i < NM; i++) begin
        if (m_hs[i]) begin
          if (m_beat[i] == m_len[i]) begin
            m_out[i] = 0;
            m_done[i]++;
          end
          m_beat[i] = m_beat[i] + 1'b1;
        end
        if (m_arhs[i]) begin
          m_pend[i] = 0; m_out[i] = 1; m_beat[i] = '0;
        end
      end
      if (done_o != '0) begin
        gnt = '0;
      end else if (gnt == '0 && req_o != '0) begin
        found = 0;
        for (int k = 1; k <= NM; k++) begin
          if (!found && req_o[(rr + k) % NM]) begin
            found = 1;
            rr    = (rr + k) % NM;
            gnt   = NM'(1) << rr;
          end
        end
      end
    end
    idle_all = !s_busy;
    for (int i = 0; i < NM; i++) idle_all = idle_all && !m_pend[i] && !m_out[i];
    check("drain_idle", idle_all, 1'b1);
    for (int i = 0; i < NM; i++) check("progress", (m_done[i] >= 10), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
